// File: rtl/p_scatter_pkg.sv
// p_scatter_pkg: shared constants, FSM encoding and element slice helper for p_scatter_8
package p_scatter_pkg;
    localparam logic [31:0] INVALID_COL = 32'hFFFF_FFFF;
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
    // LSB position of element r in a word of nu elements of ew bits; element 0 sits at the MSB end
    function automatic int elem_lsb(input int r, input int nu, input int ew);
        return (nu - 1 - r) * ew;
    endfunction
endpackage

// File: rtl/p_scatter_merge.sv
// p_scatter_merge: folds every pending lane that targets word d_sel into the read word
module p_scatter_merge
    import p_scatter_pkg::*;
#(
    parameter int no_of_elements_in_input = 8,
    parameter int element_width = 32,
    parameter int no_of_units = 8
) (
    input  logic [no_of_units*element_width-1:0]             rd_word,
    input  logic [31:0]                                      d_sel,
    input  logic [no_of_elements_in_input*32-1:0]            col_nos,
    input  logic [no_of_elements_in_input*element_width-1:0] input_row,
    input  logic [no_of_elements_in_input-1:0]               pending,
    output logic [no_of_units*element_width-1:0]             merged,
    output logic [no_of_elements_in_input-1:0]               cleared
);
    localparam int SH = $clog2(no_of_units);
    localparam int PW = $clog2(no_of_units * element_width);
    logic [PW-1:0] pos;
    // ascending lane order lets the highest lane win when several hit the same element
    always_comb begin
        merged = rd_word;
        cleared = '0;
        pos = '0;
        for (int i = 0; i < no_of_elements_in_input; i++) begin
            if (pending[i] && (col_nos[i*32 +: 32] >> SH) == d_sel) begin
                cleared[i] = 1'b1;
                pos = PW'(elem_lsb(int'(col_nos[i*32 +: 32] & 32'(no_of_units - 1)), no_of_units, element_width));
                merged[pos +: element_width] = input_row[i*element_width +: element_width];
            end
        end
    end
endmodule

// File: rtl/p_scatter_8.sv
// p_scatter_8: scatters a row of 8 column-tagged elements into a banked vector memory, one RMW per distinct word
// Optional debug read port enabled by defining P_SCATTER_READBACK_EN.
module p_scatter_8
    import p_scatter_pkg::*;
#(
    parameter int no_of_elements_in_input = 8,
    parameter int element_width = 32,
    parameter int no_of_units = 8,
    parameter int mem_depth = 4096
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             row_valid,
    output logic                                             I_am_ready,
    input  logic [no_of_elements_in_input*32-1:0]            col_nos,
    input  logic [no_of_elements_in_input*element_width-1:0] input_row,
    output logic                                             write_done,
    output logic                                             addr_err
`ifdef P_SCATTER_READBACK_EN
    ,
    input  logic [31:0]                                      dbg_addr,
    output logic [no_of_units*element_width-1:0]             dbg_data
`endif
);
    localparam int NL = no_of_elements_in_input;
    localparam int SH = $clog2(no_of_units);
    localparam int AW = $clog2(mem_depth);
    localparam int WW = no_of_units * element_width;
    state_t state, state_n;
    logic [NL*32-1:0] cols_q;
    logic [NL*element_width-1:0] row_q;
    logic [NL-1:0] pend_q, in_range, cleared, pend_left;
    logic err_q, in_err;
    logic [31:0] d_sel, d_sel_q;
    logic [WW-1:0] rd_q, merged;
    logic [WW-1:0] mem [mem_depth] = '{default: '0};

    assign pend_left = pend_q & ~cleared;

    // classify incoming lanes: valid in-range lanes become pending, out-of-range lanes only raise the error
    always_comb begin
        in_range = '0;
        in_err = 1'b0;
        for (int i = 0; i < NL; i++) begin
            if (col_nos[i*32 +: 32] != INVALID_COL) begin
                if ((col_nos[i*32 +: 32] >> SH) < 32'(mem_depth)) in_range[i] = 1'b1;
                else in_err = 1'b1;
            end
        end
    end

    // word targeted next is the one owned by the lowest-numbered pending lane
    always_comb begin
        d_sel = '0;
        for (int i = NL - 1; i >= 0; i--) if (pend_q[i]) d_sel = cols_q[i*32 +: 32] >> SH;
    end

    // state register
    always_ff @(posedge clk) state <= rst ? IDLE : state_n;

    // next-state: one RD/WR pair per distinct word, then a single DONE cycle
    always_comb begin
        state_n = state == IDLE ? (row_valid ? (|in_range ? RD : DONE) : IDLE) :
                  state == RD   ? WR :
                  state == WR   ? (|pend_left ? RD : DONE) : IDLE;
    end

    // row capture and pending-lane bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            err_q <= 1'b0;
        end else if (state == IDLE && row_valid) begin
            cols_q <= col_nos;
            row_q <= input_row;
            pend_q <= in_range;
            err_q <= in_err;
        end else if (state == WR) begin
            pend_q <= pend_left;
        end
    end

    // memory: registered read in RD, merged write-back in WR unless reset lands on the same edge
    always_ff @(posedge clk) begin
        if (state == RD) begin
            rd_q <= mem[d_sel[AW-1:0]];
            d_sel_q <= d_sel;
        end
        if (state == WR && !rst) mem[d_sel_q[AW-1:0]] <= merged;
    end

    p_scatter_merge #(
        .no_of_elements_in_input(NL),
        .element_width(element_width),
        .no_of_units(no_of_units)
    ) u_merge (
        .rd_word(rd_q),
        .d_sel(d_sel_q),
        .col_nos(cols_q),
        .input_row(row_q),
        .pending(pend_q),
        .merged(merged),
        .cleared(cleared)
    );

    // status outputs decoded from state
    always_comb begin
        I_am_ready = state == IDLE;
        write_done = state == DONE;
        addr_err = state == DONE && err_q;
    end

`ifdef P_SCATTER_READBACK_EN
    // debug read port: one-cycle latency, old data on a same-cycle write, zero when out of range
    always_ff @(posedge clk)
        dbg_data <= rst ? '0 : (dbg_addr < 32'(mem_depth) ? mem[dbg_addr[AW-1:0]] : '0);
`endif
endmodule

// File: tb/tb_p_scatter_8.sv
// tb_p_scatter_8: randomized and directed self-checking bench for p_scatter_8 against a column-level memory model
module tb_p_scatter_8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic row_valid = 1'b0;
    logic I_am_ready, write_done, addr_err;
    logic [255:0] col_nos = '0;
    logic [255:0] input_row = '0;
    logic [255:0] ref_mem [4096];
    int touched[$];
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    p_scatter_8 dut (
        .clk(clk),
        .rst(rst),
        .row_valid(row_valid),
        .I_am_ready(I_am_ready),
        .col_nos(col_nos),
        .input_row(input_row),
        .write_done(write_done),
        .addr_err(addr_err)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // reference: word = col/8, element = col%8 at MSB end, later lanes overwrite earlier ones
    task automatic model(input logic [255:0] cols, input logic [255:0] vals, output int k, output bit err);
        bit seen [int];
        logic [31:0] c, w;
        int e;
        err = 1'b0;
        touched.delete();
        for (int i = 0; i < 8; i++) begin
            c = cols[i*32 +: 32];
            if (c != 32'hFFFF_FFFF) begin
                w = c / 8;
                if (w >= 4096) err = 1'b1;
                else begin
                    e = int'(c % 8);
                    ref_mem[w][(7 - e)*32 +: 32] = vals[i*32 +: 32];
                    if (!seen.exists(int'(w))) begin
                        seen[int'(w)] = 1'b1;
                        touched.push_back(int'(w));
                    end
                end
            end
        end
        k = seen.num();
    endtask

    task automatic scan_mem(input string name);
        int bad = 0;
        for (int w = 0; w < 4096; w++) if (dut.mem[w] !== ref_mem[w]) bad++;
        check({name, ":memscan"}, bad, 0);
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!I_am_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, ":ready"}, I_am_ready, 1'b1);
    endtask

    task automatic run_row(input string name, input logic [255:0] cols, input logic [255:0] vals);
        int k, n;
        bit err;
        wait_ready(name);
        @(negedge clk);
        col_nos = cols;
        input_row = vals;
        row_valid = 1'b1;
        model(cols, vals, k, err);
        @(posedge clk);
        #1;
        row_valid = 1'b0;
        col_nos = {8{$urandom()}};
        input_row = {8{$urandom()}};
        check({name, ":busy"}, I_am_ready, 1'b0);
        n = 0;
        while (!write_done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, ":latency"}, n, 2 * k);
        check({name, ":addr_err"}, addr_err, err);
        check({name, ":ready_in_done"}, I_am_ready, 1'b0);
        @(posedge clk);
        #1;
        check({name, ":ready_after"}, I_am_ready, 1'b1);
        check({name, ":done_pulse"}, write_done, 1'b0);
        foreach (touched[j]) check($sformatf("%s:word%0d", name, touched[j]), dut.mem[touched[j]], ref_mem[touched[j]]);
        scan_mem(name);
    endtask

    initial begin
        logic [255:0] c, v;
        int k, seen_done;
        for (int w = 0; w < 4096; w++) ref_mem[w] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset:ready", I_am_ready, 1'b1);
        check("reset:write_done", write_done, 1'b0);
        check("reset:addr_err", addr_err, 1'b0);
        scan_mem("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin c[i*32 +: 32] = 32'(9 * i); v[i*32 +: 32] = 32'hA0 + 32'(i); end
        run_row("diag", c, v);
        for (int i = 0; i < 8; i++) begin c[i*32 +: 32] = 32'(16 + i); v[i*32 +: 32] = 32'(i + 1); end
        run_row("oneword", c, v);
        check("oneword:value", dut.mem[2], 256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008);
        for (int i = 0; i < 8; i++) begin c[i*32 +: 32] = 32'd5; v[i*32 +: 32] = 32'(i); end
        run_row("dup", c, v);
        c = {8{32'hFFFF_FFFF}};
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
        run_row("allinv", c, v);
        for (int i = 0; i < 8; i++) begin c[i*32 +: 32] = 32'(8 * (10 + i) + i); v[i*32 +: 32] = $urandom(); end
        c[3*32 +: 32] = 32'd32768;
        run_row("oor", c, v);

        c = {8{32'hFFFF_FFFF}};
        c[0 +: 32] = 32'd41;
        c[32 +: 32] = 32'd50;
        v = {8{32'h5A5A_1234}};
        wait_ready("rstmid");
        @(negedge clk);
        col_nos = c;
        input_row = v;
        row_valid = 1'b1;
        @(posedge clk);
        #1;
        row_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rstmid:ready", I_am_ready, 1'b1);
        check("rstmid:write_done", write_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (write_done) seen_done++;
        end
        check("rstmid:no_done", seen_done, 0);
        scan_mem("rstmid");

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 8; i++) begin
                k = int'($urandom_range(0, 15));
                c[i*32 +: 32] = k == 0 ? 32'hFFFF_FFFF :
                                k == 1 ? 32'd32768 + $urandom_range(0, 1 << 20) :
                                k == 2 ? 32'hFFFF_FFF0 : $urandom_range(0, 95);
                v[i*32 +: 32] = $urandom();
            end
            run_row($sformatf("rnd%0d", t), c, v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/p_scatter_8.md
# p_scatter_8

Write-side counterpart of the P_Emap gather path: accepts a row of up to 8 element values, each tagged with a column number, and scatters them into a banked vector memory. Each memory word holds `no_of_units` packed elements; column c maps to word c/no_of_units, element c%no_of_units. Lanes hitting the same word are coalesced into one read-modify-write. Sits after the multiply/accumulate units and writes result vectors back into the store that the gather units read from.

## Interface
- `no_of_elements_in_input`, 8, lanes per input row (fixed at 8 for this block)
- `element_width`, 32, bits per element
- `no_of_units`, 8, elements per memory word (power of 2)
- `mem_depth`, 4096, number of memory words
- `clk`  in  1  clock; all logic on posedge
- `rst`  in  1  reset; synchronous, active-high
- `row_valid`  in  1  input row present
- `I_am_ready`  out  1  block can accept a row
- `col_nos`  in  8*32  column number per lane; lane 7 = bits [255:224], lane 0 = [31:0]; 32'hFFFFFFFF = invalid lane
- `input_row`  in  8*element_width  element value per lane, same lane ordering
- `write_done`  out  1  one-cycle pulse: row fully committed
- `addr_err`  out  1  valid only with `write_done`: at least one lane's word index was ≥ `mem_depth`

## Operation
- Element r within a word occupies bits [(no_of_units-r)*element_width-1 -: element_width] (element 0 at MSB end).
- States:
  - IDLE: `I_am_ready`=1.
  - RD: read mem[d_sel].
  - WR: merge and write back.
  - DONE: `write_done`=1.
- In IDLE, `row_valid`&&`I_am_ready` captures `col_nos`, `input_row`, and the pending mask. A lane is pending iff its address ≠ invalid and its word index is < `mem_depth`.
  - Out-of-range lanes are dropped and set the error flag.
  - Mask non-zero → RD; mask zero → DONE.
- RD: d_sel = word index of the lowest-numbered pending lane. Issue a registered read of mem[d_sel]. Next state WR.
- WR: start from the read word. For each pending lane with word index = d_sel, replace its element, applying lanes in ascending order so the highest lane wins on duplicates. Write the result to mem[d_sel] and clear those lanes.
  - Remaining mask non-zero → RD; zero → DONE.
- DONE: one cycle, then IDLE.
- `row_valid` is ignored outside IDLE; the upstream stage holds the row until accepted.
- Divide/modulo by `no_of_units` are shift/mask; the word index is compared against `mem_depth` at full 32 bits.
- Memory contents are not affected by `rst`. They are zeroed at time 0.

## Timing
- Reset values: `I_am_ready`=1 (state IDLE), `write_done`=0, `addr_err`=0, pending mask=0.
- Let E0 be the accepting edge and k the number of distinct valid words in the row.
  - `write_done` is high in the cycle after edge E0+2k.
  - `I_am_ready` returns to 1 one cycle later.
  - k=0 → `write_done` in the cycle after E0.
- Throughput: one row per 2k+2 cycles.
- `I_am_ready`=0 in RD, WR, DONE.
- `rst` mid-operation: state goes to IDLE on that edge and the pending row is discarded. A WR write on the same edge is suppressed. Words already written stay written.
- Back-to-back rows touching the same word: no hazard, because rows are strictly serialized.

## Configuration
- `P_SCATTER_READBACK_EN` defined:
  - Adds `dbg_addr` (in, 32) and `dbg_data` (out, no_of_units*element_width).
  - `dbg_data` <= mem[dbg_addr] every cycle, independent of the FSM, with 1-cycle latency.
  - A same-cycle WR to the same word returns the old data.
  - `dbg_data` resets to 0.
  - An out-of-range `dbg_addr` returns 0.
- Undefined: the ports are absent and the memory has a single read port.

## Structure
- Package `p_scatter_pkg`:
  - INVALID_COL (32'hFFFFFFFF)
  - state enum (IDLE/RD/WR/DONE)
  - function returning the element slice position for a given r
- Sub-module `p_scatter_merge`: combinational. Inputs are the read word, d_sel, lane addresses, values, and pending mask. Outputs are the merged word and the lanes-cleared mask.
- The top level holds the FSM, capture registers, and memory array.

## Test plan
- Lane i col = 9i, value = 32'hA0+i → k=8, `write_done` 17 cycles after accept. Word i element i = A0+i; all other elements unchanged.
- Lanes col 16..23, values 1..8 → k=1, `write_done` at E0+2. Word 2 = {1,2,...,8}, element 0 = 1.
- All lanes col 5, value = lane id → element 5 of word 0 = 7; the other elements of word 0 keep their previous values.
- All lanes invalid → `write_done` the cycle after accept, `addr_err`=0, no memory change.
- Lane 3 col = `mem_depth`*8, others valid distinct words → lane 3 dropped, `addr_err`=1 with `write_done`, other lanes written.
- `rst` high on the edge ending the first WR of a k=2 row → mem unchanged for that word, `I_am_ready`=1 next cycle, no `write_done`.
